// File: rtl/dsram_responder.sv
// rtl/dsram_responder.sv - data_sram responder: 1-cycle SRAM with lane enables, window check, clear sweep
// Optional statistics counters are built when DSRAM_STAT_EN is defined.
module dsram_responder #(
    parameter int          AW        = 8,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        init_done,
    output logic [15:0] err_cnt,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_idx;
    logic          clr_last;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic          in_range;
    logic          accept;
    logic          reject;
    logic          wr_acc;
    logic          rd_acc;
    logic [31:0]   old_word;
    logic [31:0]   merged;
    logic [1:0]    unused_addr_lsb;

    assign unused_addr_lsb = data_sram_addr[1:0];

    assign idx      = data_sram_addr[AW+1:2];
    assign in_range = (data_sram_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign accept   = data_sram_en && (state == RUN) && in_range;
    assign reject   = data_sram_en && !((state == RUN) && in_range);
    assign wr_acc   = accept && (data_sram_wen != 4'b0000);
    assign rd_acc   = accept && (data_sram_wen == 4'b0000);
    assign clr_last = (clr_idx == {AW{1'b1}});
    assign old_word = mem[idx];

    // Write-first merge; with wen==0 this is simply the stored word.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) begin
                merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_last) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= CLEAR;
            clr_idx         <= '0;
            init_done       <= 1'b0;
            data_sram_rdata <= 32'h0;
            err_cnt         <= 16'h0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_last) begin
                    init_done <= 1'b1;
                end
            end
            if (accept) begin
                data_sram_rdata <= merged;
            end else if (reject) begin
                data_sram_rdata <= 32'h0;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
        end
    end

    // The array has no reset; the sweep owns the write port while in CLEAR.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= 32'h0;
        end else if (wr_acc) begin
            mem[idx] <= merged;
        end
    end

`ifdef DSRAM_STAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt <= 32'h0;
            wr_cnt <= 32'h0;
        end else begin
            if (rd_acc) rd_cnt <= rd_cnt + 32'd1;
            if (wr_acc) wr_cnt <= wr_cnt + 32'd1;
        end
    end
`else
    logic unused_stat;
    assign unused_stat = rd_acc ^ wr_acc;
    assign rd_cnt = 32'h0;
    assign wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dsram_responder.sv
// tb/tb_dsram_responder.sv - self-checking bench for dsram_responder
module tb_dsram_responder;

`ifdef DSRAM_STAT_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        init_done;
    logic [15:0] err_cnt;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    always #5 clk = ~clk;

    dsram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .init_done       (init_done),
        .err_cnt         (err_cnt),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [256];
    logic [31:0] exp_rdata;
    int          model_err;
    logic [31:0] model_rd;
    logic [31:0] model_wr;
    int          sweep_edges;

    // Edges since reset release; the array is usable after 256 of them.
    always @(posedge clk or posedge reset) begin
        if (reset) sweep_edges <= 0;
        else if (sweep_edges < 100000) sweep_edges <= sweep_edges + 1;
    end

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [15];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        exp_rdata = 32'h0;
        model_err = 0;
        model_rd  = 32'h0;
        model_wr  = 32'h0;
    endtask

    task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        bit run;
        int i;
        @(negedge clk);
        run   = (sweep_edges >= 256);
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        if (e) begin
            if (run && ((a >> 10) == (32'h8000_0000 >> 10))) begin
                i = int'(a[9:2]);
                for (int l = 0; l < 4; l++)
                    if (w[l]) model_mem[i][8*l +: 8] = d[8*l +: 8];
                exp_rdata = model_mem[i];
                if (w != 4'b0000) model_wr++;
                else model_rd++;
            end else begin
                exp_rdata = 32'h0;
                if (model_err < 65535) model_err++;
            end
        end
        #1;
        check32("rdata", rdata, exp_rdata);
        check32("init_done", {31'b0, init_done}, {31'b0, sweep_edges >= 256});
        check32("err_cnt", {16'b0, err_cnt}, model_err);
        check32("rd_cnt", rd_cnt, STAT_ON ? model_rd : 32'h0);
        check32("wr_cnt", wr_cnt, STAT_ON ? model_wr : 32'h0);
        en = 1'b0;
    endtask

    task automatic sweep_wait();
        for (int k = 0; k < 257; k++) req(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        vt[0]  = '{1'b1, 4'h0, 32'h8000_0040, 32'h0,         32'h0};
        vt[1]  = '{1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 4'h0, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF};
        vt[3]  = '{1'b1, 4'h4, 32'h8000_0010, 32'h5A5A_5A5A, 32'hDE5A_BEEF};
        vt[4]  = '{1'b1, 4'h0, 32'h8000_0010, 32'h0,         32'hDE5A_BEEF};
        vt[5]  = '{1'b1, 4'h3, 32'h8000_0010, 32'h1234_1234, 32'hDE5A_1234};
        vt[6]  = '{1'b1, 4'h0, 32'h8000_0010, 32'h0,         32'hDE5A_1234};
        vt[7]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h0};
        vt[8]  = '{1'b0, 4'h0, 32'h8000_0010, 32'h0,         32'h0};
        vt[9]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0};
        vt[10] = '{1'b1, 4'h0, 32'h8000_0013, 32'h0,         32'hDE5A_1234};
        vt[11] = '{1'b1, 4'h0, 32'h8000_0400, 32'h0,         32'h0};
        vt[12] = '{1'b1, 4'hF, 32'h8000_03FC, 32'hA5A5_0001, 32'hA5A5_0001};
        vt[13] = '{1'b1, 4'h0, 32'h8000_0000, 32'h0,         32'h0};
        vt[14] = '{1'b1, 4'h0, 32'h8000_03FC, 32'h0,         32'hA5A5_0001};

        reset = 1'b1;
        en    = 1'b0;
        wen   = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check32("reset_rdata", rdata, 32'h0);
        check32("reset_init_done", {31'b0, init_done}, 32'h0);
        check32("reset_err_cnt", {16'b0, err_cnt}, 32'h0);
        check32("reset_rd_cnt", rd_cnt, 32'h0);
        check32("reset_wr_cnt", wr_cnt, 32'h0);

        // Sweep with one request landing mid-CLEAR.
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 257; k++)
            req(k == 10, 4'hF, 32'h8000_0010, 32'hFFFF_FFFF);
        check32("clear_reject_err", {16'b0, err_cnt}, 32'd1);

        for (int v = 0; v < 15; v++) begin
            req(vt[v].en, vt[v].wen, vt[v].addr, vt[v].wdata);
            check32($sformatf("vec%0d", v), rdata, vt[v].exp);
        end

        for (int r = 0; r < 2000; r++) begin
            logic [31:0] a;
            logic [3:0]  w;
            if ($urandom_range(0, 9) == 0) a = $urandom();
            else a = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            req($urandom_range(0, 4) != 0, w, a, $urandom());
        end

        // Saturation: a long run of out-of-window requests.
        @(negedge clk);
        en   = 1'b1;
        wen  = 4'h0;
        addr = 32'h0000_0010;
        repeat (65540) @(posedge clk);
        #1;
        en = 1'b0;
        model_err = 65535;
        exp_rdata = 32'h0;
        check32("sat_err_cnt", {16'b0, err_cnt}, 32'h0000_FFFF);
        check32("sat_rdata", rdata, 32'h0);
        req(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        check32("sat_hold", {16'b0, err_cnt}, 32'h0000_FFFF);

        // Asynchronous reset during a read stream.
        req(1'b1, 4'hF, 32'h8000_0010, 32'hCAFE_F00D);
        req(1'b1, 4'h0, 32'h8000_0010, 32'h0);
        en   = 1'b1;
        wen  = 4'h0;
        addr = 32'h8000_0010;
        #1;
        reset = 1'b1;
        #1;
        check32("async_rdata", rdata, 32'h0);
        check32("async_err_cnt", {16'b0, err_cnt}, 32'h0);
        check32("async_init_done", {31'b0, init_done}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        sweep_wait();
        req(1'b1, 4'h0, 32'h8000_0010, 32'h0);
        check32("post_reset_read", rdata, 32'h0);

        // Statistics: 3 writes, 5 reads, 2 rejected.
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        sweep_wait();
        for (int k = 0; k < 3; k++) req(1'b1, 4'hF, 32'h8000_0020 + 32'(k * 4), 32'h1111_0000 + 32'(k));
        for (int k = 0; k < 5; k++) req(1'b1, 4'h0, 32'h8000_0020 + 32'((k % 3) * 4), 32'h0);
        req(1'b1, 4'h0, 32'h4000_0000, 32'h0);
        req(1'b1, 4'hF, 32'h8000_0800, 32'h0);
        check32("stat_wr_cnt", wr_cnt, STAT_ON ? 32'd3 : 32'd0);
        check32("stat_rd_cnt", rd_cnt, STAT_ON ? 32'd5 : 32'd0);
        check32("stat_err_cnt", {16'b0, err_cnt}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
